// File: rtl/boot_pkg.sv
// Shared types and helpers for the instruction-memory boot controller.
// BOOT_CHECKSUM_EN adds a trailing XOR checksum byte to every boot frame.
package boot_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } boot_state_e;

    // State entered once the payload (or an empty frame) is complete.
    function automatic boot_state_e payload_end_state();
`ifdef BOOT_CHECKSUM_EN
        return CSUM;
`else
        return DONE;
`endif
    endfunction

    function automatic logic [BYTE_W-1:0] csum_update(input logic [BYTE_W-1:0] acc,
                                                      input logic [BYTE_W-1:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; word_valid pulses
// combinationally on the fourth byte of each word.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;
    logic [WORD_W-1:0] merged_s;

    // New bytes enter at the top so byte 0 ends up in bits [7:0].
    assign merged_s = {byte_data, shift_q[WORD_W-1:BYTE_W]};
    assign word     = merged_s;

    // Byte counter and shift register next-state.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clr) begin
            cnt_d   = 2'd0;
            shift_d = {WORD_W{1'b0}};
        end else if (byte_valid) begin
            cnt_d      = cnt_q + 2'd1;
            shift_d    = merged_s;
            word_valid = (cnt_q == 2'd3);
        end else begin
            cnt_d   = cnt_q;
            shift_d = shift_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= {WORD_W{1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed byte image into instruction memory,
// then releases the core. BOOT_CHECKSUM_EN enables the trailing XOR checksum check.
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int IMEM_AW    = 10,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    input  logic               boot_req,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               core_rst_n,
    output logic               boot_done,
    output logic               boot_err
);

    localparam logic [LEN_W:0]     DEPTH_L  = IMEM_DEPTH[LEN_W:0];
    localparam logic [IMEM_AW-1:0] ADDR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};

    boot_state_e        state_q;
    boot_state_e        state_d;
    logic [BYTE_W-1:0]  len_lo_q;
    logic [BYTE_W-1:0]  len_lo_d;
    logic [LEN_W-1:0]   left_q;
    logic [LEN_W-1:0]   left_d;
    logic [IMEM_AW-1:0] idx_q;
    logic [IMEM_AW-1:0] idx_d;
    logic               in_ready_q;
    logic               in_ready_d;
    logic               imem_we_q;
    logic               imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [IMEM_AW-1:0] imem_addr_d;
    logic [WORD_W-1:0]  imem_wdata_q;
    logic [WORD_W-1:0]  imem_wdata_d;
    logic               boot_done_q;
    logic               boot_done_d;
    logic               boot_err_q;
    logic               boot_err_d;
    logic               core_rst_n_q;
    logic               core_rst_n_d;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q;
    logic [BYTE_W-1:0]  csum_d;
`endif

    logic               xfer_s;
    logic               restart_s;
    logic               pack_valid_s;
    logic               word_valid_s;
    logic [WORD_W-1:0]  word_s;
    logic [LEN_W-1:0]   len_full_s;
    logic               len_too_big_s;

    assign xfer_s        = in_valid & in_ready_q;
    assign restart_s     = boot_req & ((state_q == DONE) | (state_q == ERR));
    assign pack_valid_s  = xfer_s & (state_q == DATA);
    assign len_full_s    = {in_data, len_lo_q};
    assign len_too_big_s = ({1'b0, len_full_s} > DEPTH_L);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (restart_s),
        .byte_valid (pack_valid_s),
        .byte_data  (in_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN0: begin
                if (xfer_s) state_d = LEN1;
                else        state_d = state_q;
            end
            LEN1: begin
                if (!xfer_s)                        state_d = state_q;
                else if (len_full_s == 16'd0)       state_d = payload_end_state();
                else if (len_too_big_s)             state_d = ERR;
                else                                state_d = DATA;
            end
            DATA: begin
                if (word_valid_s && (left_q == 16'd0)) state_d = payload_end_state();
                else                                   state_d = state_q;
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (!xfer_s)                state_d = state_q;
                else if (in_data == csum_q) state_d = DONE;
                else                        state_d = ERR;
            end
`endif
            DONE, ERR: begin
                if (restart_s) state_d = LEN0;
                else           state_d = state_q;
            end
            default: state_d = ERR;
        endcase
    end

    // Length capture, word counters, checksum and memory write port.
    always_comb begin
        len_lo_d     = len_lo_q;
        left_d       = left_q;
        idx_d        = idx_q;
        imem_we_d    = word_valid_s;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (restart_s) begin
            len_lo_d = 8'd0;
            left_d   = 16'd0;
            idx_d    = {IMEM_AW{1'b0}};
        end else if ((state_q == LEN0) && xfer_s) begin
            len_lo_d = in_data;
        end else if ((state_q == LEN1) && xfer_s) begin
            // Holds the number of words still to come after the current one.
            left_d = len_full_s - 16'd1;
        end else if (word_valid_s) begin
            left_d       = left_q - 16'd1;
            idx_d        = idx_q + ADDR_ONE;
            imem_addr_d  = idx_q;
            imem_wdata_d = word_s;
        end else begin
            len_lo_d = len_lo_q;
        end
`ifdef BOOT_CHECKSUM_EN
        csum_d = csum_q;
        if (restart_s)         csum_d = 8'd0;
        else if (pack_valid_s) csum_d = csum_update(csum_q, in_data);
        else                   csum_d = csum_q;
`endif
    end

    // Status outputs; release lags the final write by one cycle.
    always_comb begin
        in_ready_d = 1'b0;
        case (state_d)
            LEN0, LEN1, DATA, CSUM: in_ready_d = 1'b1;
            default:                in_ready_d = 1'b0;
        endcase
        boot_done_d  = (state_q == DONE) && (state_d == DONE);
        boot_err_d   = (state_d == ERR);
        core_rst_n_d = boot_done_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LEN0;
            len_lo_q     <= 8'd0;
            left_q       <= 16'd0;
            idx_q        <= {IMEM_AW{1'b0}};
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {IMEM_AW{1'b0}};
            imem_wdata_q <= 32'd0;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            left_q       <= left_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            boot_done_q  <= boot_done_d;
            boot_err_q   <= boot_err_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign boot_done  = boot_done_q;
    assign boot_err   = boot_err_q;
    assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl against a frame-level model.
// Builds with or without BOOT_CHECKSUM_EN.
module tb_imem_boot_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          boot_req;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          boot_done;
    logic          boot_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  payload_q[$];
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    longint      last_we_t   = -1;
    longint      done_t      = -1;
    longint      err_t       = -1;
    longint      last_xfer_t = -1;
    int          viol        = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl #(.IMEM_AW(AW), .IMEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .boot_req   (boot_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    // Write/status monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(int'(imem_addr));
            obs_data.push_back(imem_wdata);
            last_we_t = $time;
        end
        if (boot_done && done_t < 0) done_t = $time;
        if (boot_err && err_t < 0) err_t = $time;
        if (imem_we && core_rst_n) viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit pick_gap(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return bit'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // Presents one byte and holds it until the controller takes it.
    task automatic push_byte(input logic [7:0] b, input bit gap);
        int waited = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        last_xfer_t = $time + 5;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        payload_q.delete();
        for (int i = 0; i < 4 * n; i++) payload_q.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [31:0] model_word(input int w);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < 4; k++) v = v + (32'(payload_q[4 * w + k]) << (8 * k));
        return v;
    endfunction

    task automatic restart();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        check_eq("req_core_rst_n", 32'(core_rst_n), 32'd0);
        check_eq("req_boot_done", 32'(boot_done), 32'd0);
        check_eq("req_boot_err", 32'(boot_err), 32'd0);
        check_eq("req_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Sends one frame of n words and checks the writes and final status.
    task automatic run_frame(input int n, input int gap_mode, input bit bad_csum, input bit req_mid);
        logic [15:0] len;
        logic [7:0]  x;
        bit          exp_err;
        int          exp_writes;
        longint      seen_t;
        len = 16'(n);
        x   = 8'h00;
        foreach (payload_q[i]) x = x ^ payload_q[i];
        exp_err    = (n > DEPTH) || (CSUM_EN && bad_csum);
        exp_writes = (n > DEPTH) ? 0 : n;
        obs_addr.delete();
        obs_data.delete();
        last_we_t = -1;
        done_t    = -1;
        err_t     = -1;
        push_byte(len[7:0], pick_gap(gap_mode));
        push_byte(len[15:8], pick_gap(gap_mode));
        if (n <= DEPTH) begin
            foreach (payload_q[i]) begin
                if (req_mid && i == 2) begin
                    boot_req = 1'b1;
                    @(negedge clk);
                    boot_req = 1'b0;
                end
                push_byte(payload_q[i], pick_gap(gap_mode));
            end
            if (CSUM_EN) push_byte(bad_csum ? (x ^ 8'h01) : x, pick_gap(gap_mode));
        end
        for (int i = 0; i < 40 && !(boot_done || boot_err); i++) @(negedge clk);
        @(negedge clk);
        check_eq("boot_done", 32'(boot_done), 32'(!exp_err));
        check_eq("boot_err", 32'(boot_err), 32'(exp_err));
        check_eq("core_rst_n", 32'(core_rst_n), 32'(!exp_err));
        check_eq("in_ready_idle", 32'(in_ready), 32'd0);
        check_eq("n_writes", 32'(obs_addr.size()), 32'(exp_writes));
        for (int i = 0; i < obs_addr.size() && i < exp_writes; i++) begin
            check_eq("wr_addr", 32'(obs_addr[i]), 32'(i));
            check_eq("wr_data", obs_data[i], model_word(i));
        end
        seen_t = exp_err ? err_t : done_t;
        check_eq("status_lat", 32'(seen_t - last_xfer_t), exp_err ? 32'd5 : 32'd15);
        if (!exp_err && exp_writes > 0)
            check_eq("we_before_release", 32'(last_we_t < done_t), 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        boot_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_imem_we", 32'(imem_we), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_imem_wdata", imem_wdata, 32'd0);
        check_eq("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check_eq("rst_boot_done", 32'(boot_done), 32'd0);
        check_eq("rst_boot_err", 32'(boot_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_in_ready", 32'(in_ready), 32'd1);

        payload_q = '{8'h13, 8'h05, 8'h50, 8'h00};
        run_frame(1, 0, 1'b0, 1'b0);
        check_eq("t1_word", (obs_data.size() > 0) ? obs_data[0] : 32'hxxxxxxxx, 32'h00500513);
        restart();

        fill_random(3);
        run_frame(3, 1, 1'b0, 1'b0);
        restart();

        payload_q.delete();
        run_frame(1025, 0, 1'b0, 1'b0);
        restart();

        // Abort mid-load with reset after six payload bytes.
        fill_random(3);
        obs_addr.delete();
        obs_data.delete();
        push_byte(8'h03, 1'b0);
        push_byte(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) push_byte(payload_q[i], 1'b0);
        @(negedge clk);
        check_eq("abort_writes", 32'(obs_addr.size()), 32'd1);
        check_eq("abort_word", (obs_data.size() > 0) ? obs_data[0] : 32'hxxxxxxxx, model_word(0));
        rst = 1'b0;
        #1;
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        check_eq("abort_core_rst_n", 32'(core_rst_n), 32'd0);
        check_eq("abort_imem_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_random(2);
        run_frame(2, 2, 1'b0, 1'b0);
        restart();

        fill_random(2);
        run_frame(2, 0, 1'b0, 1'b1);
        restart();

        payload_q.delete();
        run_frame(0, 2, 1'b0, 1'b0);
        restart();

        fill_random(DEPTH);
        run_frame(DEPTH, 0, 1'b0, 1'b0);
        restart();

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(0, 6);
            fill_random(n);
            run_frame(n, $urandom_range(0, 2), 1'b0, 1'b0);
            restart();
        end

        payload_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(1, 0, 1'b0, 1'b0);
        restart();
        run_frame(1, 2, 1'b1, 1'b0);
        restart();

        check_eq("we_with_release", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
